// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and packing helpers for the matrix sequencer
// and the core-side command encoder.
package matmul_pkg;

   localparam int unsigned DW     = 32;
   localparam int unsigned N      = 4;
   localparam int unsigned LANES  = 4;
   localparam int unsigned MAT_W  = DW * N * N;
   localparam int unsigned MUL_W  = 256;
   localparam int unsigned MAT_AW = $clog2(MAT_W);
   localparam int unsigned MUL_AW = $clog2(MUL_W);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } mseq_state_t;

   // Bit offset of element [r][c] in a packed row-major matrix.
   function automatic logic [MAT_AW-1:0] mat_elem(input int unsigned r, input int unsigned c);
      return MAT_AW'(DW * (N * r + c));
   endfunction

   // Bit offset of lane k on the multiplier buses.
   function automatic logic [MUL_AW-1:0] lane(input int unsigned k);
      return MUL_AW'(DW * k);
   endfunction

endpackage

// File: rtl/matmul_lane_adder.sv
// Wrapping 32-bit sum of the four lane products returned by the multiplier.
module matmul_lane_adder
   import matmul_pkg::*;
(
   input  logic [MUL_W-1:0] mul_result_i,
   output logic [DW-1:0]    sum_o
);

   // Lanes above LANES carry nothing meaningful.
   logic unused_hi;
   assign unused_hi = ^mul_result_i[MUL_W-1:LANES*DW];

   // Accumulate lanes; overflow wraps modulo 2^32 by construction.
   always_comb begin
      sum_o = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         sum_o = sum_o + mul_result_i[lane(k) +: DW];
      end
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences a 4x4 matrix product through the shared 4-lane multiplier, one
// row-by-column pass per output element, with a watchdog on each pass.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [MAT_W-1:0] cmd_a,
   input  logic [MAT_W-1:0] cmd_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [MAT_W-1:0] rsp_c,
   output logic             rsp_err,
   output logic             busy,
   output logic             mul_start,
   output logic [MUL_W-1:0] mul_a,
   output logic [MUL_W-1:0] mul_b,
   input  logic             mul_done,
   input  logic [MUL_W-1:0] mul_result
);

   localparam int unsigned   EW     = $clog2(N * N);
   localparam int unsigned   WdW    = $clog2(TIMEOUT + 1);
   localparam logic [EW-1:0]  ELast  = EW'(N * N - 1);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   mseq_state_t        state_q;
   logic [MAT_W-1:0]   a_q, b_q, c_q;
   logic [EW-1:0]      e_q;
   logic [WdW-1:0]     wd_q;
   logic               err_q, rsp_valid_q, mul_start_q;
   logic [MUL_W-1:0]   mul_a_q, mul_b_q;

   logic [EW-1:0]      e_nxt;
   logic [MAT_W-1:0]   src_a, src_b;
   logic [MUL_W-1:0]   op_a, op_b;
   logic [MAT_AW-1:0]  cur_off;
   logic [DW-1:0]      lane_sum;

   matmul_lane_adder u_lane_adder (
      .mul_result_i (mul_result),
      .sum_o        (lane_sum)
   );

   // Operands for the next element to issue: taken straight from the command
   // port on acceptance, from the latched copies while a command is running.
   always_comb begin
      e_nxt   = (state_q == StIdle) ? '0 : e_q + EW'(1);
      src_a   = (state_q == StIdle) ? cmd_a : a_q;
      src_b   = (state_q == StIdle) ? cmd_b : b_q;
      op_a    = '0;
      op_b    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         op_a[lane(k) +: DW] = src_a[mat_elem(32'(e_nxt) / N, k) +: DW];
         op_b[lane(k) +: DW] = src_b[mat_elem(k, 32'(e_nxt) % N) +: DW];
      end
      cur_off = mat_elem(32'(e_q) / N, 32'(e_q) % N);
   end

   // Control FSM with registered multiplier and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         e_q         <= '0;
         wd_q        <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         mul_start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  a_q         <= cmd_a;
                  b_q         <= cmd_b;
                  e_q         <= '0;
                  mul_a_q     <= op_a;
                  mul_b_q     <= op_b;
                  mul_start_q <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               wd_q    <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (mul_done) begin
                  c_q[cur_off +: DW] <= lane_sum;
                  if (e_q == ELast) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= StResp;
                  end else begin
                     e_q         <= e_nxt;
                     mul_a_q     <= op_a;
                     mul_b_q     <= op_b;
                     mul_start_q <= 1'b1;
                     state_q     <= StIssue;
                  end
               end else if (wd_q == WdLast) begin
                  // This cycle is the TIMEOUT-th silent WAIT cycle: abort.
                  c_q         <= '0;
                  err_q       <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  wd_q <= wd_q + WdW'(1);
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_c     = c_q;
   assign rsp_err   = err_q;
   assign mul_start = mul_start_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: behavioural multiplier with configurable latency
// and spurious done pulses, plus a plain-arithmetic matrix-product reference.
module tb_matmul_sequencer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [511:0] cmd_a = '0;
   logic [511:0] cmd_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [511:0] rsp_c;
   logic         rsp_err;
   logic         busy;
   logic         mul_start;
   logic [255:0] mul_a;
   logic [255:0] mul_b;
   logic         mul_done = 1'b0;
   logic [255:0] mul_result = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulses = 0;
   int upper_bad = 0;
   int lat_cfg = 1;
   bit stall = 1'b0;
   bit spurious = 1'b0;
   int left = 0;

   matmul_sequencer #(
      .TIMEOUT (15)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_c      (rsp_c),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_done   (mul_done),
      .mul_result (mul_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model: lane products appear lat_cfg edges after a start,
   // computed from the operands present at that time; upper result bits are junk.
   always @(posedge clk) begin
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
      if (mul_start) begin
         pulses <= pulses + 1;
         if (mul_a[255:128] !== '0 || mul_b[255:128] !== '0) upper_bad <= upper_bad + 1;
      end
      if (mul_start && !stall) left = lat_cfg;
      if (left > 0) begin
         left = left - 1;
         if (left == 0) begin
            for (int k = 0; k < 4; k++) r[32*k +: 32] = mul_a[32*k +: 32] * mul_b[32*k +: 32];
            mul_done <= 1'b1;
         end else begin
            mul_done <= 1'b0;
         end
      end else begin
         mul_done <= spurious && !stall && ($urandom_range(0, 2) == 0);
      end
      mul_result <= r;
   end

   function automatic logic [511:0] ref_mm(input logic [511:0] a, input logic [511:0] b);
      logic [511:0] c;
      logic [31:0]  s;
      c = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = '0;
            for (int k = 0; k < 4; k++) s = s + a[32*(4*i+k) +: 32] * b[32*(4*k+j) +: 32];
            c[32*(4*i+j) +: 32] = s;
         end
      end
      return c;
   endfunction

   function automatic logic [511:0] rand_mat();
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
      return m;
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full command: accept, wait for the response, optionally stall the
   // consumer for `hold` cycles while poking cmd_valid, then complete it.
   task automatic run_cmd(input logic [511:0] a, input logic [511:0] b, input int hold,
                          input logic [511:0] exp, output logic [511:0] c, output logic e,
                          output int lat, output int np);
      int e0, p0, n;
      @(negedge clk);
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
      rsp_ready = 1'b0;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("accept_timeout", cmd_ready, 1'b1);
      p0 = pulses;
      @(negedge clk);
      e0 = cyc;
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) check("rsp_timeout", rsp_valid, 1'b1);
      lat = cyc - e0;
      c = rsp_c;
      e = rsp_err;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_a = rand_mat();
         @(negedge clk);
         check("hold_rsp_valid", rsp_valid, 1'b1);
         check("hold_rsp_c", rsp_c, exp);
         check("hold_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      np = pulses - p0;
      check("post_hs_rsp_valid", rsp_valid, 1'b0);
      check("post_hs_cmd_ready", cmd_ready, 1'b1);
      check("post_hs_rsp_err", rsp_err, 1'b0);
   endtask

   initial begin
      logic [511:0] a, b, c, exp;
      logic         e;
      int           lat, np, base, nrsp, n;
      int           acc[$];

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_flags", {rsp_valid, rsp_err, busy, mul_start}, 4'b0000);
      check("rst_rsp_c", rsp_c, '0);
      check("rst_mul_ops", {mul_a, mul_b}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Identity times a counting matrix
      a = '0;
      b = '0;
      for (int r = 0; r < 4; r++) begin
         a[32*(5*r) +: 32] = 32'd1;
         for (int q = 0; q < 4; q++) b[32*(4*r+q) +: 32] = 32'(4*r + q + 1);
      end
      run_cmd(a, b, 0, b, c, e, lat, np);
      check("ident_c", c, b);
      check("ident_err", e, 1'b0);
      check("ident_latency", lat, 32);
      check("ident_pulses", np, 16);

      // All 2 times all -3
      for (int i = 0; i < 16; i++) begin
         a[32*i +: 32] = 32'd2;
         b[32*i +: 32] = -32'sd3;
         exp[32*i +: 32] = 32'hFFFF_FFE8;
      end
      run_cmd(a, b, 0, exp, c, e, lat, np);
      check("neg_c", c, exp);
      check("neg_err", e, 1'b0);

      // Wrapping product in C[0][0]
      a = '0;
      b = '0;
      a[31:0] = 32'h7FFF_FFFF;
      b[31:0] = 32'd4;
      exp = '0;
      exp[31:0] = 32'hFFFF_FFFC;
      run_cmd(a, b, 0, exp, c, e, lat, np);
      check("wrap_c", c, exp);

      // Consumer stalls for 10 cycles
      a = rand_mat();
      b = rand_mat();
      exp = ref_mm(a, b);
      run_cmd(a, b, 10, exp, c, e, lat, np);
      check("hold_c", c, exp);
      check("hold_pulses", np, 16);

      // Back-to-back with rsp_ready tied high
      @(negedge clk);
      a = rand_mat();
      b = rand_mat();
      exp = ref_mm(a, b);
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      nrsp = 0;
      for (int t = 0; t < 110; t++) begin
         if (acc.size() >= 2) cmd_valid = 1'b0;
         if (cmd_valid && cmd_ready) acc.push_back(cyc);
         if (rsp_valid) begin
            nrsp++;
            check("b2b_c", rsp_c, exp);
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      check("b2b_accepts", acc.size(), 2);
      if (acc.size() >= 2) check("b2b_spacing", acc[1] - acc[0], 34);
      check("b2b_responses", nrsp, 2);

      // Watchdog abort
      stall = 1'b1;
      a = rand_mat();
      b = rand_mat();
      run_cmd(a, b, 0, '0, c, e, lat, np);
      check("wd_err", e, 1'b1);
      check("wd_c", c, '0);
      check("wd_latency", lat, 16);
      check("wd_pulses", np, 1);
      stall = 1'b0;

      // Reset in the middle of a command
      @(negedge clk);
      cmd_a = rand_mat();
      cmd_b = rand_mat();
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      check("midrst_flags", {rsp_valid, rsp_err, busy, mul_start}, 4'b0000);
      check("midrst_rsp_c", rsp_c, '0);
      check("midrst_mul_ops", {mul_a, mul_b}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = pulses;
      nrsp = 0;
      repeat (50) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
      end
      check("midrst_no_rsp", nrsp, 0);
      check("midrst_no_start", pulses - base, 0);
      a = rand_mat();
      b = rand_mat();
      exp = ref_mm(a, b);
      run_cmd(a, b, 0, exp, c, e, lat, np);
      check("after_rst_c", c, exp);
      check("after_rst_latency", lat, 32);

      // Random matrices, multiplier latency and consumer stalls, spurious done
      spurious = 1'b1;
      for (int it = 0; it < 6; it++) begin
         lat_cfg = $urandom_range(1, 6);
         a = rand_mat();
         b = rand_mat();
         exp = ref_mm(a, b);
         run_cmd(a, b, $urandom_range(0, 3), exp, c, e, lat, np);
         check("rand_c", c, exp);
         check("rand_err", e, 1'b0);
         check("rand_pulses", np, 16);
      end
      spurious = 1'b0;

      check("upper_operand_zero", upper_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
